noc_ingress_arbiter: RTL

NOC_INGRESS_ARBITER -- requirements
Module: noc_ingress_arbiter

---
 rtl/noc_ingress_arbiter_if.sv | 53 +++++
 rtl/noc_ingress_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/noc_ingress_arbiter_if.sv
// ---------------------------------------------------------------------------
// noc_ingress_arbiter_if
// Bundles the four source write ports, the downstream stall and the issue
// outputs of noc_ingress_arbiter.
//   master : the side that writes sources and consumes issued transfers
//   slave  : the arbiter itself
// Signals
//   wr_X / din_X / dst_X : source write strobe, payload, destination (X=A..D)
//   full_X               : source FIFO full flag
//   stall                : downstream not accepting, freezes issue
//   port_X               : payload towards NOC input port X
//   In_add / out_add     : source index / destination index of the transfer
//   LOAD / en_X          : transfer strobe / one-hot destination enable
//   drop_cnt             : saturating count of rejected writes
// ---------------------------------------------------------------------------
interface noc_ingress_arbiter_if #(
  parameter int DW = 8
);
  logic          wr_A, wr_B, wr_C, wr_D;
  logic [DW-1:0] din_A, din_B, din_C, din_D;
  logic [1:0]    dst_A, dst_B, dst_C, dst_D;
  logic          full_A, full_B, full_C, full_D;
  logic          stall;
  logic [DW-1:0] port_A, port_B, port_C, port_D;
  logic [1:0]    In_add, out_add;
  logic          LOAD;
  logic          en_A, en_B, en_C, en_D;
  logic [7:0]    drop_cnt;

  modport master (
    output wr_A, wr_B, wr_C, wr_D,
    output din_A, din_B, din_C, din_D,
    output dst_A, dst_B, dst_C, dst_D,
    output stall,
    input  full_A, full_B, full_C, full_D,
    input  port_A, port_B, port_C, port_D,
    input  In_add, out_add, LOAD,
    input  en_A, en_B, en_C, en_D,
    input  drop_cnt
  );

  modport slave (
    input  wr_A, wr_B, wr_C, wr_D,
    input  din_A, din_B, din_C, din_D,
    input  dst_A, dst_B, dst_C, dst_D,
    input  stall,
    output full_A, full_B, full_C, full_D,
    output port_A, port_B, port_C, port_D,
    output In_add, out_add, LOAD,
    output en_A, en_B, en_C, en_D,
    output drop_cnt
  );
endinterface

// File: rtl/noc_ingress_arbiter.sv
// ---------------------------------------------------------------------------
// noc_ingress_arbiter
// Four source FIFOs (entry = {dst, payload}) feeding a round-robin arbiter
// that issues at most one registered transfer per cycle towards the NOC.
// Ports
//   CLK : clock, all state on the rising edge
//   RES : asynchronous active-low reset
//   bus : noc_ingress_arbiter_if.slave (writes, stall, issue outputs, flags)
// Parameters
//   DEPTH : entries per source FIFO (power of 2, >= 2)
//   DW    : payload width
// ---------------------------------------------------------------------------
module noc_ingress_arbiter #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                  CLK,
  input  logic                  RES,
  noc_ingress_arbiter_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DW + 2;

  // Source-indexed views of the named interface signals
  logic [3:0]    w_wr;
  logic [DW-1:0] w_din [4];
  logic [1:0]    w_dst [4];

  assign w_wr     = {bus.wr_D, bus.wr_C, bus.wr_B, bus.wr_A};
  assign w_din[0] = bus.din_A;
  assign w_din[1] = bus.din_B;
  assign w_din[2] = bus.din_C;
  assign w_din[3] = bus.din_D;
  assign w_dst[0] = bus.dst_A;
  assign w_dst[1] = bus.dst_B;
  assign w_dst[2] = bus.dst_C;
  assign w_dst[3] = bus.dst_D;

  logic [3:0]    w_full;
  logic [3:0]    w_nonempty;
  logic [3:0]    w_push;
  logic [3:0]    w_pop;
  logic [EW-1:0] w_head [4];

  logic          w_found;
  logic          w_issue;
  logic [1:0]    w_winner;
  logic [1:0]    w_idx;
  logic [EW-1:0] w_sel;
  logic [1:0]    w_sel_dst;
  logic [DW-1:0] w_sel_data;

  logic [1:0]    r_rr;
  logic          r_load;
  logic [1:0]    r_in_add;
  logic [1:0]    r_out_add;
  logic [3:0]    r_en;
  logic [DW-1:0] r_port [4];
  logic [7:0]    r_drop_cnt;

  // -------------------------------------------------------------------------
  // Per-source FIFOs
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fifo
      logic [EW-1:0] r_mem [DEPTH];
      logic [AW-1:0] r_wptr;
      logic [AW-1:0] r_rptr;
      logic [CW-1:0] r_count;

      // Full is taken from the registered count, so a write into a full FIFO
      // is rejected even when that FIFO is popped in the same cycle.
      assign w_full[gi]     = (r_count == CW'(DEPTH));
      assign w_nonempty[gi] = (r_count != '0);
      assign w_push[gi]     = w_wr[gi] & ~w_full[gi];
      assign w_pop[gi]      = w_issue & (w_winner == 2'(gi));
      assign w_head[gi]     = r_mem[r_rptr];

      // Storage carries no reset; validity is tracked by the pointers.
      always_ff @(posedge CLK) begin
        if (w_push[gi]) begin
          r_mem[r_wptr] <= {w_dst[gi], w_din[gi]};
        end
      end

      // Pointers are AW bits wide, so incrementing wraps modulo DEPTH.
      always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
          r_wptr  <= '0;
          r_rptr  <= '0;
          r_count <= '0;
        end else begin
          if (w_push[gi]) begin
            r_wptr <= r_wptr + 1'b1;
          end
          if (w_pop[gi]) begin
            r_rptr <= r_rptr + 1'b1;
          end
          case ({w_push[gi], w_pop[gi]})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
          endcase
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Round-robin search starting at r_rr
  // -------------------------------------------------------------------------
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_rr;
    w_idx    = r_rr;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_rr + 2'(k);
      if (!w_found && w_nonempty[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_issue    = w_found & ~bus.stall;
  assign w_sel      = w_head[w_winner];
  assign w_sel_dst  = w_sel[EW-1:DW];
  assign w_sel_data = w_sel[DW-1:0];

  // -------------------------------------------------------------------------
  // Issue registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      r_rr      <= 2'd0;
      r_load    <= 1'b0;
      r_in_add  <= 2'd0;
      r_out_add <= 2'd0;
      r_en      <= 4'd0;
      for (int k = 0; k < 4; k++) begin
        r_port[k] <= '0;
      end
    end else begin
      r_load <= w_issue;
      r_en   <= w_issue ? (4'b0001 << w_sel_dst) : 4'b0000;
      if (w_issue) begin
        r_rr      <= w_winner + 2'd1;
        r_in_add  <= w_winner;
        r_out_add <= w_sel_dst;
        for (int k = 0; k < 4; k++) begin
          r_port[k] <= (w_winner == 2'(k)) ? w_sel_data : '0;
        end
      end else if (!bus.stall) begin
        // Idle cycle: ports clear, addresses hold. Under stall all hold.
        for (int k = 0; k < 4; k++) begin
          r_port[k] <= '0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Drop counter: every rejected write on every source counts, saturating.
  // -------------------------------------------------------------------------
  logic [2:0] w_drops;
  logic [8:0] w_drop_sum;

  always_comb begin
    w_drops = 3'd0;
    for (int k = 0; k < 4; k++) begin
      w_drops = w_drops + 3'(w_wr[k] & w_full[k]);
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + 9'(w_drops);

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      r_drop_cnt <= 8'd0;
    end else begin
      r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.full_A   = w_full[0];
  assign bus.full_B   = w_full[1];
  assign bus.full_C   = w_full[2];
  assign bus.full_D   = w_full[3];
  assign bus.port_A   = r_port[0];
  assign bus.port_B   = r_port[1];
  assign bus.port_C   = r_port[2];
  assign bus.port_D   = r_port[3];
  assign bus.In_add   = r_in_add;
  assign bus.out_add  = r_out_add;
  assign bus.LOAD     = r_load;
  assign bus.en_A     = r_en[0];
  assign bus.en_B     = r_en[1];
  assign bus.en_C     = r_en[2];
  assign bus.en_D     = r_en[3];
  assign bus.drop_cnt = r_drop_cnt;
endmodule
